// File: rtl/ula_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : ula_pkg
//  Description : Shared types and constants for the ULA result path
//                (FSM encoding and BCD digit constants).
//  Revision    : 1.0 - initial release
// ============================================================================
package ula_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        SHIFT = 2'b01,
        DONE  = 2'b10
    } state_t;

    localparam int BCD_DIGIT_W    = 4;
    localparam int ADD3_THRESHOLD = 5;

endpackage : ula_pkg
`default_nettype wire

// File: rtl/bcd_result_converter_if.sv
`default_nettype none
// ============================================================================
//  Module      : bcd_result_converter_if
//  Description : Start/busy/done handshake plus data buses between the
//                multiplier-side requester and the BCD converter.
//  Revision    : 1.0 - initial release
// ============================================================================
interface bcd_result_converter_if #(
    parameter int WIDTH  = 8,
    parameter int DIGITS = 3
);
    logic                start;
    logic [WIDTH-1:0]    bin;
    logic                busy;
    logic                done;
    logic [4*DIGITS-1:0] bcd;

    modport master (
        output start,
        output bin,
        input  busy,
        input  done,
        input  bcd
    );

    modport slave (
        input  start,
        input  bin,
        output busy,
        output done,
        output bcd
    );
endinterface : bcd_result_converter_if
`default_nettype wire

// File: rtl/bcd_add3_digit.sv
`default_nettype none
// ============================================================================
//  Module      : bcd_add3_digit
//  Description : Double-dabble digit correction: adds 3 to a BCD digit that
//                is 5 or more so the following left shift carries correctly.
//  Revision    : 1.0 - initial release
// ============================================================================
module bcd_add3_digit
    import ula_pkg::*;
(
    input  wire logic [BCD_DIGIT_W-1:0] digit_in,
    output logic      [BCD_DIGIT_W-1:0] digit_out
);

    // Pre-shift digits never exceed 9, so the 4-bit sum cannot wrap.
    assign digit_out = (digit_in >= BCD_DIGIT_W'(ADD3_THRESHOLD))
                     ? digit_in + BCD_DIGIT_W'(3)
                     : digit_in;

endmodule : bcd_add3_digit
`default_nettype wire

// File: rtl/bcd_result_converter.sv
`default_nettype none
// ============================================================================
//  Module      : bcd_result_converter
//  Description : Sequential binary-to-BCD converter (shift-and-add-3, one
//                bit per clock) feeding the seven-segment display drivers.
//  Revision    : 1.0 - initial release
// ============================================================================
module bcd_result_converter
    import ula_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int DIGITS = 3
) (
    input  wire logic                    clk,
    input  wire logic                    rst,
    bcd_result_converter_if.slave        bus
);

    localparam int DIG_W  = BCD_DIGIT_W * DIGITS;
    localparam int WORK_W = DIG_W + WIDTH;
    localparam int CNT_W  = $clog2(WIDTH + 1);

    state_t             r_state;
    state_t             w_state_next;
    logic [WIDTH-1:0]   r_shift;
    logic [DIG_W-1:0]   r_digits;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_busy;
    logic               r_done;
    logic [DIG_W-1:0]   r_bcd;

    logic [DIG_W-1:0]   w_corr;
    logic [WORK_W-1:0]  w_work;
    logic [WORK_W-1:0]  w_work_next;
    logic               w_last;

    // Per-digit add-3 correction applied before every shift.
    for (genvar k = 0; k < DIGITS; k++) begin : g_add3
        bcd_add3_digit u_add3 (
            .digit_in  (r_digits[BCD_DIGIT_W*k +: BCD_DIGIT_W]),
            .digit_out (w_corr  [BCD_DIGIT_W*k +: BCD_DIGIT_W])
        );
    end

    assign w_work      = {w_corr, r_shift};
    assign w_work_next = w_work << 1;
    assign w_last      = (r_cnt == CNT_W'(1));

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic: start is only honoured in IDLE; DONE lasts one cycle.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (bus.start) w_state_next = SHIFT;
            SHIFT:   if (w_last)    w_state_next = DONE;
            DONE:    w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    // Datapath: capture on accept, correct-then-shift while converting,
    // and load the result from the final shifted digits on the last step.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_shift  <= '0;
            r_digits <= '0;
            r_cnt    <= '0;
            r_bcd    <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (bus.start) begin
                        r_shift  <= bus.bin;
                        r_digits <= '0;
                        r_cnt    <= CNT_W'(WIDTH);
                    end
                end
                SHIFT: begin
                    r_shift  <= w_work_next[WIDTH-1:0];
                    r_digits <= w_work_next[WORK_W-1:WIDTH];
                    r_cnt    <= r_cnt - CNT_W'(1);
                    if (w_last) begin
                        r_bcd <= w_work_next[WORK_W-1:WIDTH];
                    end
                end
                default: ;
            endcase
        end
    end

    // Registered status flags, decoded from the state being entered.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_busy <= 1'b0;
            r_done <= 1'b0;
        end else begin
            r_busy <= (w_state_next == SHIFT);
            r_done <= (w_state_next == DONE);
        end
    end

    assign bus.busy = r_busy;
    assign bus.done = r_done;
    assign bus.bcd  = r_bcd;

endmodule : bcd_result_converter
`default_nettype wire

// File: tb/tb_bcd_result_converter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_bcd_result_converter
//  Description : Scoreboard testbench for bcd_result_converter.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_bcd_result_converter;

    localparam int WIDTH  = 8;
    localparam int DIGITS = 3;
    localparam int DIG_W  = 4 * DIGITS;

    logic clk;
    logic rst;

    bcd_result_converter_if #(.WIDTH(WIDTH), .DIGITS(DIGITS)) bus ();

    bcd_result_converter #(.WIDTH(WIDTH), .DIGITS(DIGITS)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    logic [DIG_W-1:0] exp_q[$];
    int               m_state;
    int               m_cnt;
    logic [DIG_W-1:0] m_last;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [DIG_W-1:0] to_bcd(input int v);
        logic [DIG_W-1:0] r;
        int x;
        r = '0;
        x = v;
        for (int k = 0; k < DIGITS; k++) begin
            r[4*k +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // Reference timing model: 0=idle, 1=converting, 2=result cycle.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_state <= 0;
            m_cnt   <= 0;
            exp_q.delete();
        end else begin
            case (m_state)
                0: if (bus.start) begin
                       exp_q.push_back(to_bcd(int'(bus.bin)));
                       m_state <= 1;
                       m_cnt   <= WIDTH;
                   end
                1: begin
                       if (m_cnt == 1) m_state <= 2;
                       m_cnt <= m_cnt - 1;
                   end
                default: m_state <= 0;
            endcase
        end
    end

    // Per-cycle output checking against the model and scoreboard.
    always @(negedge clk) begin
        if (rst) begin
            m_last = '0;
        end else begin
            check_eq("busy", 32'(bus.busy), 32'(m_state == 1));
            check_eq("done", 32'(bus.done), 32'(m_state == 2));
            if (bus.done) begin
                if (exp_q.size() == 0) begin
                    check_eq("unexpected_done", 32'(bus.bcd), 32'hFFFF_FFFF);
                end else begin
                    m_last = exp_q.pop_front();
                    check_eq("bcd_result", 32'(bus.bcd), 32'(m_last));
                end
            end else begin
                check_eq("bcd_hold", 32'(bus.bcd), 32'(m_last));
            end
        end
    end

    task automatic wait_done(input int max_cycles);
        for (int i = 0; i < max_cycles; i++) begin
            @(negedge clk);
            if (bus.done) return;
        end
        check_eq("done_timeout", 32'(bus.done), 32'd1);
    endtask

    task automatic convert(input int value);
        @(negedge clk);
        bus.bin   = 8'(value);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        wait_done(WIDTH + 4);
        @(negedge clk);
    endtask

    int done_cnt;
    int done_cyc[3];

    initial begin
        rst       = 1'b1;
        bus.start = 1'b0;
        bus.bin   = '0;
        repeat (3) @(negedge clk);
        check_eq("rst_busy", 32'(bus.busy), 32'd0);
        check_eq("rst_done", 32'(bus.done), 32'd0);
        check_eq("rst_bcd",  32'(bus.bcd),  32'd0);
        rst = 1'b0;

        // Basic conversions, including add-3 boundary values.
        convert(0);
        convert(255);
        convert(165);
        convert(99);

        // A start during conversion must be ignored.
        @(negedge clk);
        bus.bin   = 8'd37;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (2) @(negedge clk);
        bus.bin   = 8'd200;
        bus.start = 1'b1;
        repeat (3) @(negedge clk);
        bus.start = 1'b0;
        wait_done(WIDTH + 4);
        repeat (12) @(negedge clk);

        // Held start: back-to-back conversions every WIDTH+2 cycles.
        bus.bin   = 8'd128;
        bus.start = 1'b1;
        done_cnt  = 0;
        for (int i = 0; i < 40 && done_cnt < 3; i++) begin
            @(negedge clk);
            if (bus.done) begin
                done_cyc[done_cnt] = cyc;
                done_cnt++;
            end
        end
        bus.start = 1'b0;
        check_eq("held_done_count", 32'(done_cnt), 32'd3);
        if (done_cnt == 3) begin
            check_eq("held_period_1", 32'(done_cyc[1] - done_cyc[0]), 32'(WIDTH + 2));
            check_eq("held_period_2", 32'(done_cyc[2] - done_cyc[1]), 32'(WIDTH + 2));
        end
        repeat (WIDTH + 4) @(negedge clk);

        // Asynchronous reset mid-conversion discards the partial result.
        bus.bin   = 8'd77;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (4) @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        check_eq("async_rst_busy", 32'(bus.busy), 32'd0);
        check_eq("async_rst_done", 32'(bus.done), 32'd0);
        check_eq("async_rst_bcd",  32'(bus.bcd),  32'd0);
        @(negedge clk);
        #2;
        rst = 1'b0;
        convert(42);

        repeat (4) @(negedge clk);
        check_eq("scoreboard_empty", 32'(exp_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_bcd_result_converter
`default_nettype wire
